// File: rtl/route_buffer.sv
// ---------------------------------------------------------------------------
// route_buffer
//   Single-flit input buffer for a 2D mesh router node. Incoming flits are
//   queued in a DEPTH-entry FIFO together with an XY route select computed at
//   push time. The head entry drives the downstream 1-to-4 demux.
//
// Ports
//   clk        in   single clock, all state on rising edge
//   rst_n      in   synchronous active-low reset
//   in_data    in   incoming flit; dest_x = in_data[1:0], dest_y = in_data[3:2]
//   in_valid   in   upstream flit present
//   in_ready   out  buffer can accept a flit (registered state only)
//   out_data   out  head flit, zero when empty
//   out_sel    out  head route select (01 X+, 10 X-, 11 Y, 00 local)
//   out_valid  out  head flit valid
//   out_ready  in   downstream accepts head flit
//   fwd_cnt    out  saturating count of forwarded flits
// ---------------------------------------------------------------------------
module route_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int MY_X   = 0,
    parameter int MY_Y   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        fwd_cnt
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0]      MY_X_C   = 2'(MY_X);
    localparam logic [1:0]      MY_Y_C   = 2'(MY_Y);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [1:0]        sel_q  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [7:0]        fwd_cnt_q, fwd_cnt_d;

    logic              push;
    logic              pop;
    logic [1:0]        dest_x;
    logic [1:0]        dest_y;
    logic [1:0]        route_sel;

    // Both handshake outputs depend on the registered count only, so a pop
    // in a full cycle cannot open in_ready until the next cycle.
    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign dest_x = in_data[1:0];
    assign dest_y = in_data[3:2];

    // XY dimension-order routing: resolve X first, then Y, else local.
    always_comb begin
        route_sel = 2'b00;
        if (dest_x > MY_X_C) begin
            route_sel = 2'b01;
        end else if (dest_x < MY_X_C) begin
            route_sel = 2'b10;
        end else if (dest_y != MY_Y_C) begin
            route_sel = 2'b11;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        fwd_cnt_d = fwd_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (fwd_cnt_q != 8'hFF) begin
                fwd_cnt_d = fwd_cnt_q + 8'd1;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            fwd_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fwd_cnt_q <= fwd_cnt_d;
        end
    end

    // Storage is not reset; a write during reset is harmless because the
    // pointers and count are cleared in the same edge.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= in_data;
            sel_q[wr_ptr_q]  <= route_sel;
        end
    end

    assign out_data = out_valid ? data_q[rd_ptr_q] : '0;
    assign out_sel  = out_valid ? sel_q[rd_ptr_q]  : 2'b00;
    assign fwd_cnt  = fwd_cnt_q;

endmodule

// File: tb/tb_route_buffer.sv
// ---------------------------------------------------------------------------
// tb_route_buffer
//   Self-checking bench for route_buffer at node (1,1), DEPTH=4, DATA_W=16.
//   Expected flits are queued when pushed and compared when popped; every
//   cycle also checks handshake flags, head contents and fwd_cnt.
// ---------------------------------------------------------------------------
module tb_route_buffer;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        sel;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_sel;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        fwd_cnt;

    route_buffer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .MY_X  (1),
        .MY_Y  (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_sel  (out_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fwd_cnt  (fwd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb[$];
    int   m_fwd    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input logic [1:0] x, input logic [1:0] y,
                                            input logic [11:0] hi);
        return {hi, y, x};
    endfunction

    // Reference XY route for node (1,1).
    function automatic logic [1:0] route(input logic [DATA_W-1:0] d);
        logic [1:0] dx, dy;
        dx = d[1:0];
        dy = d[3:2];
        if (dx > 2'd1)      return 2'b01;
        else if (dx < 2'd1) return 2'b10;
        else if (dy != 2'd1) return 2'b11;
        else                return 2'b00;
    endfunction

    // One clock: drive inputs, compare any flit leaving, advance, update model.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [1:0] esel,
                         input logic r, input logic rs);
        logic do_push, do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        rst_n     = rs;
        do_push = rs && v && (sb.size() < DEPTH);
        do_pop  = rs && r && (sb.size() > 0);
        if (do_pop) begin
            chk("pop_data", 32'(out_data), 32'(sb[0].data));
            chk("pop_sel",  32'(out_sel),  32'(sb[0].sel));
        end
        @(posedge clk);
        #1;
        if (!rs) begin
            sb.delete();
            m_fwd = 0;
        end else begin
            if (do_pop) begin
                void'(sb.pop_front());
                if (m_fwd != 255) m_fwd++;
            end
            if (do_push) sb.push_back('{d, esel});
        end
        chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
        chk("in_ready",  32'(in_ready),  32'(sb.size() < DEPTH));
        chk("fwd_cnt",   32'(fwd_cnt),   32'(m_fwd));
        if (sb.size() > 0) begin
            chk("head_data", 32'(out_data), 32'(sb[0].data));
            chk("head_sel",  32'(out_sel),  32'(sb[0].sel));
        end else begin
            chk("idle_data", 32'(out_data), 32'd0);
            chk("idle_sel",  32'(out_sel),  32'd0);
        end
    endtask

    task automatic rand_cycle(input logic v, input logic r);
        logic [DATA_W-1:0] d;
        d = DATA_W'($urandom);
        cycle(v, d, route(d), r, 1'b1);
    endtask

    vec_t              tbl [7];
    logic [DATA_W-1:0] f [5];

    initial begin
        tbl[0] = '{mk(2'd2, 2'd1, 12'hA01), 2'b01};
        tbl[1] = '{mk(2'd0, 2'd1, 12'hA02), 2'b10};
        tbl[2] = '{mk(2'd1, 2'd3, 12'hA03), 2'b11};
        tbl[3] = '{mk(2'd1, 2'd1, 12'hA04), 2'b00};
        tbl[4] = '{mk(2'd3, 2'd0, 12'hB05), 2'b01};
        tbl[5] = '{mk(2'd0, 2'd3, 12'hB06), 2'b10};
        tbl[6] = '{mk(2'd1, 2'd0, 12'hB07), 2'b11};

        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;

        // Reset state
        cycle(1'b0, '0, 2'b00, 1'b0, 1'b0);
        cycle(1'b1, 16'hFFFF, 2'b00, 1'b1, 1'b0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fwd", 32'(fwd_cnt), 32'd0);

        // Routing table, streamed with out_ready=1
        for (int unsigned i = 0; i < 4; i++) begin
            cycle(1'b1, tbl[i].data, tbl[i].sel, 1'b1, 1'b1);
            chk("stream_latency", 32'(out_data), 32'(tbl[i].data));
        end
        cycle(1'b0, '0, 2'b00, 1'b1, 1'b1);
        chk("fwd_after_4", 32'(fwd_cnt), 32'd4);
        for (int unsigned i = 4; i < 7; i++) begin
            cycle(1'b1, tbl[i].data, tbl[i].sel, 1'b0, 1'b1);
            chk("route_sel", 32'(out_sel), 32'(tbl[4].sel));
        end
        for (int unsigned i = 0; i < 4; i++) rand_cycle(1'b0, 1'b1);

        // Fill with out_ready=0; fifth flit held upstream
        for (int unsigned i = 0; i < 5; i++) f[i] = mk(2'(i), 2'(i + 1), 12'(12'hC00 + i));
        for (int unsigned i = 0; i < 5; i++) begin
            cycle(1'b1, f[i], route(f[i]), 1'b0, 1'b1);
            if (i == 3) chk("full_in_ready", 32'(in_ready), 32'd0);
        end
        chk("full_head_hold", 32'(out_data), 32'(f[0]));

        // Full: push and pop together -> pop only, in_ready next cycle
        cycle(1'b1, f[4], route(f[4]), 1'b1, 1'b1);
        chk("full_pop_ready", 32'(in_ready), 32'd1);
        chk("full_pop_head", 32'(out_data), 32'(f[1]));
        cycle(1'b1, f[4], route(f[4]), 1'b0, 1'b1);
        chk("refill_ready", 32'(in_ready), 32'd0);
        for (int unsigned i = 0; i < 4; i++) cycle(1'b0, '0, 2'b00, 1'b1, 1'b1);

        // Steady state at count=2 with pointer wrap
        rand_cycle(1'b1, 1'b0);
        rand_cycle(1'b1, 1'b0);
        for (int unsigned i = 0; i < 10; i++) rand_cycle(1'b1, 1'b1);
        rand_cycle(1'b0, 1'b1);
        chk("steady_one_left", 32'(out_valid), 32'd1);
        rand_cycle(1'b0, 1'b1);
        chk("steady_drained", 32'(out_valid), 32'd0);

        // Mid-operation reset discards buffered flits
        for (int unsigned i = 0; i < 3; i++) rand_cycle(1'b1, 1'b0);
        cycle(1'b1, 16'h1234, route(16'h1234), 1'b1, 1'b0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_fwd", 32'(fwd_cnt), 32'd0);
        for (int unsigned i = 0; i < 3; i++) rand_cycle(1'b1, 1'b0);
        for (int unsigned i = 0; i < 4; i++) rand_cycle(1'b0, 1'b1);
        chk("post_rst_fwd", 32'(fwd_cnt), 32'd3);

        // Saturation of fwd_cnt
        for (int unsigned i = 0; i < 262; i++) rand_cycle(1'b1, 1'b1);
        chk("fwd_sat", 32'(fwd_cnt), 32'd255);
        for (int unsigned i = 0; i < 3; i++) rand_cycle(1'b1, 1'b1);
        chk("fwd_hold", 32'(fwd_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/route_buffer.md
ROUTE_BUFFER -- requirements
Module: route_buffer

Interface
REQ-001 Parameters SHALL be (one per line, name, default, meaning):
- DATA_W, 16, flit width in bits
- DEPTH, 4, FIFO entries (power of two, >= 2)
- MY_X, 0, this node's X coordinate (2 bits)
- MY_Y, 0, this node's Y coordinate (2 bits)

REQ-002 Ports SHALL be (one per line, name, direction, width, meaning):
- clk, input, 1, single clock; all state updates on rising edge
- rst_n, input, 1, synchronous active-low reset
- in_data, input, DATA_W, incoming flit; dest_x = in_data[1:0], dest_y = in_data[3:2]
- in_valid, input, 1, upstream flit present
- in_ready, output, 1, buffer can accept a flit
- out_data, output, DATA_W, head flit to downstream 1-to-4 demux data path
- out_sel, output, 2, output-port select for downstream demux ctrl
- out_valid, output, 1, head flit valid
- out_ready, input, 1, downstream accepts head flit
- fwd_cnt, output, 8, saturating count of flits forwarded

Function
REQ-003 Single-flit packets only; no header/body distinction.
REQ-004 Push SHALL occur on a rising edge when in_valid=1 and in_ready=1; pop SHALL occur when out_valid=1 and out_ready=1.
REQ-005 in_ready SHALL equal (count < DEPTH); it SHALL be driven from registered state only, with no combinational path from out_ready.
REQ-006 out_valid SHALL equal (count > 0).
REQ-007 Route SHALL be computed at push time and stored with the flit (XY order):
- dest_x > MY_X -> 2'b01 (X+)
- dest_x < MY_X -> 2'b10 (X-)
- dest_x == MY_X, dest_y != MY_Y -> 2'b11 (Y)
- dest_x == MY_X, dest_y == MY_Y -> 2'b00 (local)
REQ-008 Latency: a flit pushed into an empty buffer at edge N SHALL present out_valid=1 with its data and sel after edge N (same-cycle bypass not permitted).
REQ-009 out_data and out_sel SHALL reflect the head entry when out_valid=1, and SHALL be 0 when out_valid=0.
REQ-010 Order SHALL be strict FIFO; read/write pointers SHALL wrap modulo DEPTH.
REQ-011 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve order.
REQ-012 When full (count = DEPTH), in_ready=0 and no push SHALL occur even if a pop happens in the same cycle; in_ready SHALL rise the cycle after the pop.
REQ-013 When empty, out_valid=0 and no pop SHALL occur regardless of out_ready.
REQ-014 in_data SHALL be ignored when in_valid=0 or in_ready=0; out_ready SHALL be ignored when out_valid=0.
REQ-015 fwd_cnt SHALL increment by 1 on each pop and saturate at 255.
REQ-016 Once out_valid=1, out_data and out_sel SHALL remain stable until the pop occurs.

Reset
REQ-017 When rst_n=0 at a rising edge, the block SHALL set count=0, both pointers=0 and fwd_cnt=0; on the following cycle it SHALL drive out_valid=0, out_data=0, out_sel=2'b00 and in_ready=1.
REQ-018 Reset SHALL override any push or pop in the same cycle; buffered flits SHALL be discarded; the memory contents need not be cleared.
REQ-019 Reset mid-operation SHALL be followed by normal operation on the first edge with rst_n=1.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- MY_X=1, MY_Y=1; push dest (x=2,y=1), (0,1), (1,3), (1,1) with out_ready=1 -> out_sel sequence 01, 10, 11, 00; each flit is visible 1 cycle after its push; fwd_cnt=4.
- out_ready=0; push 5 flits -> first 4 accepted, in_ready=0 after the 4th; the 5th is held upstream; out_data stays equal to flit 1.
- Full buffer; out_ready=1 and in_valid=1 in the same cycle -> pop only, count=3; in_ready=1 next cycle; then push, with order preserved.
- count=2; push and pop every cycle for 10 cycles -> count stays 2, output order matches input order, pointers wrap without loss.
- 3 flits buffered; rst_n=0 for one edge -> out_valid=0, out_sel=00, out_data=0, fwd_cnt=0, in_ready=1; old flits never appear afterwards.
- 260 flits forwarded -> fwd_cnt=255 and holds.
